// File: rtl/mos6502_serial_alu.sv
// Nibble-serial binary/BCD ALU with start/busy/done handshake; decimal adjust only under ALU_DECIMAL_EN.
// Latency: serial ops DONE in cycle after edge T+NIBBLES+1, single-step ops after edge T+2.
// Backpressure: START is ignored while BUSY; no queueing, caller re-requests after DONE.
module mos6502_serial_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nRESET,
  input  logic             START,
  input  logic [3:0]       FUNC,
  input  logic             D_FLAG,
  input  logic             CARRY_IN,
  input  logic [WIDTH-1:0] A_IN,
  input  logic [WIDTH-1:0] B_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             C_OUT,
  output logic             V_OUT,
  output logic             N_OUT,
  output logic             Z_OUT
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  localparam logic [3:0] F_ADD = 4'h0, F_SUB = 4'h1, F_AND = 4'h2, F_ORA = 4'h3,
                         F_EOR = 4'h4, F_INC = 4'h5, F_DEC = 4'h6, F_PASS = 4'h7,
                         F_LSR = 4'h8, F_ASL = 4'h9, F_ROR = 4'hA, F_ROL = 4'hB;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       func_r;
  logic [WIDTH-1:0] a_r, b_r, res_r;
  logic             carry_r;
  logic [IW-1:0]    idx;
  logic             a_msb_r, bp_msb_r;
  logic             serial;

  logic [3:0]       op_b, nib;
  logic [4:0]       sum5;
  logic             c_nxt;
  logic [WIDTH-1:0] word_res;
  logic             word_c;

`ifdef ALU_DECIMAL_EN
  logic dec_r;
`else
  logic d_flag_unused;
  assign d_flag_unused = D_FLAG;
`endif

  // INC/DEC/ADD/SUB/logic all go through the nibble path; the rest finish in one step
  assign serial = (func_r <= F_DEC);

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    BUSY      = 1'b1;
    DONE      = 1'b0;
    case (state)
      S_IDLE: begin
        BUSY = 1'b0;
        if (START) state_nxt = S_RUN;
      end
      S_RUN:  if (!serial || idx == LAST_IDX) state_nxt = S_FIN;
      S_FIN:  state_nxt = S_DONE;
      S_DONE: begin
        DONE      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // One digit step; INC/DEC were rewritten as B + 0 + 1 and B + F..F + 0 at accept
  always_comb begin
    op_b  = (func_r == F_SUB) ? ~b_r[3:0] : b_r[3:0];
    sum5  = {1'b0, a_r[3:0]} + {1'b0, op_b} + {4'b0, carry_r};
    nib   = sum5[3:0];
    c_nxt = sum5[4];
    case (func_r)
      F_AND: begin nib = a_r[3:0] & b_r[3:0]; c_nxt = 1'b0; end
      F_ORA: begin nib = a_r[3:0] | b_r[3:0]; c_nxt = 1'b0; end
      F_EOR: begin nib = a_r[3:0] ^ b_r[3:0]; c_nxt = 1'b0; end
      default: ;
    endcase
`ifdef ALU_DECIMAL_EN
    if (dec_r && func_r == F_ADD && sum5 > 5'd9) begin
      nib   = sum5[3:0] + 4'd6;
      c_nxt = 1'b1;
    end
    if (dec_r && func_r == F_SUB && !sum5[4]) nib = sum5[3:0] + 4'd10;
`endif
  end

  always_comb begin
    word_res = '0;
    word_c   = 1'b0;
    case (func_r)
      F_PASS: word_res = b_r;
      F_LSR:  begin word_res = {1'b0, b_r[WIDTH-1:1]};  word_c = b_r[0];       end
      F_ASL:  begin word_res = {b_r[WIDTH-2:0], 1'b0};  word_c = b_r[WIDTH-1]; end
      F_ROR:  begin word_res = {carry_r, b_r[WIDTH-1:1]}; word_c = b_r[0];     end
      F_ROL:  begin word_res = {b_r[WIDTH-2:0], carry_r}; word_c = b_r[WIDTH-1]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      func_r   <= '0;
      a_r      <= '0;
      b_r      <= '0;
      res_r    <= '0;
      carry_r  <= 1'b0;
      idx      <= '0;
      a_msb_r  <= 1'b0;
      bp_msb_r <= 1'b0;
      RESULT   <= '0;
      C_OUT    <= 1'b0;
      V_OUT    <= 1'b0;
      N_OUT    <= 1'b0;
      Z_OUT    <= 1'b0;
`ifdef ALU_DECIMAL_EN
      dec_r    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (START) begin
          func_r   <= FUNC;
          idx      <= '0;
          a_msb_r  <= A_IN[WIDTH-1];
          bp_msb_r <= (FUNC == F_SUB) ? ~B_IN[WIDTH-1] : B_IN[WIDTH-1];
`ifdef ALU_DECIMAL_EN
          dec_r    <= D_FLAG;
`endif
          if (FUNC == F_INC || FUNC == F_DEC) begin
            a_r     <= B_IN;
            b_r     <= (FUNC == F_DEC) ? {WIDTH{1'b1}} : '0;
            carry_r <= (FUNC == F_INC);
          end else begin
            a_r     <= A_IN;
            b_r     <= B_IN;
            carry_r <= CARRY_IN;
          end
        end
        S_RUN: if (serial) begin
          res_r   <= {nib, res_r[WIDTH-1:4]};
          a_r     <= {4'b0, a_r[WIDTH-1:4]};
          b_r     <= {4'b0, b_r[WIDTH-1:4]};
          carry_r <= c_nxt;
          idx     <= idx + 1'b1;
        end else begin
          res_r   <= word_res;
          carry_r <= word_c;
        end
        S_FIN: begin
          RESULT <= res_r;
          C_OUT  <= carry_r;
          N_OUT  <= res_r[WIDTH-1];
          Z_OUT  <= (res_r == '0);
          V_OUT  <= (func_r == F_ADD || func_r == F_SUB) &&
                    (a_msb_r ~^ bp_msb_r) && (res_r[WIDTH-1] ^ a_msb_r);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mos6502_serial_alu.sv
// Self-checking bench for mos6502_serial_alu (WIDTH=16); honours ALU_DECIMAL_EN when defined.
module tb_mos6502_serial_alu;

  localparam int W = 16;
`ifdef ALU_DECIMAL_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         nRESET = 1'b0;
  logic         START = 1'b0;
  logic [3:0]   FUNC = '0;
  logic         D_FLAG = 1'b0;
  logic         CARRY_IN = 1'b0;
  logic [W-1:0] A_IN = '0;
  logic [W-1:0] B_IN = '0;
  logic         BUSY, DONE, C_OUT, V_OUT, N_OUT, Z_OUT;
  logic [W-1:0] RESULT;

  int checks = 0;
  int errors = 0;

  mos6502_serial_alu #(.WIDTH(W)) dut (
    .clk(clk), .nRESET(nRESET), .START(START), .FUNC(FUNC), .D_FLAG(D_FLAG),
    .CARRY_IN(CARRY_IN), .A_IN(A_IN), .B_IN(B_IN), .BUSY(BUSY), .DONE(DONE),
    .RESULT(RESULT), .C_OUT(C_OUT), .V_OUT(V_OUT), .N_OUT(N_OUT), .Z_OUT(Z_OUT)
  );

  always #5 clk = ~clk;

  // Reference: returns {C, V, N, Z, R} computed word-wide (binary) or digit-by-digit (BCD)
  function automatic logic [W+3:0] model(input logic [3:0] f, input logic d, input logic ci,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r, bp;
    logic         c, v;
    int           cc, da, db, sd;
    r = '0; c = 1'b0; v = 1'b0; s = '0;
    bp = (f == 4'h1) ? ~b : b;
    case (f)
      4'h0, 4'h1: begin
        if (d && DEC_EN) begin
          cc = int'(ci);
          for (int i = 0; i < W / 4; i++) begin
            da = int'(a[4*i +: 4]);
            db = int'(bp[4*i +: 4]);
            sd = da + db + cc;
            if (f == 4'h0) begin
              if (sd > 9) begin sd = sd + 6; cc = 1; end
              else cc = 0;
            end else begin
              cc = (sd > 15) ? 1 : 0;
              sd = sd % 16;
              if (cc == 0) sd = (sd + 10) % 16;
            end
            r[4*i +: 4] = 4'(sd % 16);
          end
          c = (cc != 0);
        end else begin
          s = {1'b0, a} + {1'b0, bp} + (W+1)'(ci);
          r = s[W-1:0];
          c = s[W];
        end
        v = (a[W-1] == bp[W-1]) && (r[W-1] != a[W-1]);
      end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: begin s = {1'b0, b} + 1; r = s[W-1:0]; c = s[W]; end
      4'h6: begin s = {1'b0, b} + {1'b0, {W{1'b1}}}; r = s[W-1:0]; c = s[W]; end
      4'h7: r = b;
      4'h8: begin r = b >> 1; c = b[0]; end
      4'h9: begin r = b << 1; c = b[W-1]; end
      4'hA: begin r = {ci, b[W-1:1]}; c = b[0]; end
      4'hB: begin r = {b[W-2:0], ci}; c = b[W-1]; end
      default: r = '0;
    endcase
    return {c, v, r[W-1], (r == '0), r};
  endfunction

  // Issues one op, scrambles inputs after acceptance, reports result, latency and pulse shape
  task automatic run_op(input logic [3:0] f, input logic d, input logic ci,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output logic [3:0] fl,
                        output int lat, output bit pulse_ok);
    @(negedge clk);
    START = 1'b1; FUNC = f; D_FLAG = d; CARRY_IN = ci; A_IN = a; B_IN = b;
    @(negedge clk);
    START = 1'b0;
    FUNC = 4'($urandom); D_FLAG = 1'($urandom); CARRY_IN = 1'($urandom);
    A_IN = W'($urandom); B_IN = W'($urandom);
    lat = 0;
    while (!DONE && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!DONE) lat = -1;
    r  = RESULT;
    fl = {C_OUT, V_OUT, N_OUT, Z_OUT};
    @(negedge clk);
    pulse_ok = !DONE && !BUSY && (RESULT === r);
  endtask

  task automatic test_reset();
    nRESET = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({BUSY, DONE, RESULT, C_OUT, V_OUT, N_OUT, Z_OUT} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b r=%h cvnz=%b%b%b%b, want all 0",
               BUSY, DONE, RESULT, C_OUT, V_OUT, N_OUT, Z_OUT);
    end
    nRESET = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] f; logic d; logic ci; logic [W-1:0] a, b, r; logic [3:0] fl; int lat;
  } vec_t;

  task automatic test_directed();
    vec_t         v[10];
    logic [W-1:0] r;
    logic [3:0]   fl;
    int           lat;
    bit           pok;
    v[0] = '{4'h0, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0110, 5};
`ifdef ALU_DECIMAL_EN
    v[1] = '{4'h0, 1'b1, 1'b0, 16'h0999, 16'h0001, 16'h1000, 4'b0000, 5};
    v[2] = '{4'h0, 1'b1, 1'b0, 16'h9999, 16'h0001, 16'h0000, 4'b1001, 5};
    v[3] = '{4'h1, 1'b1, 1'b1, 16'h1000, 16'h0001, 16'h0999, 4'b1000, 5};
    v[4] = '{4'h1, 1'b1, 1'b1, 16'h0000, 16'h0001, 16'h9999, 4'b0010, 5};
`else
    v[1] = '{4'h0, 1'b1, 1'b0, 16'h0999, 16'h0001, 16'h099A, 4'b0000, 5};
    v[2] = '{4'h0, 1'b1, 1'b0, 16'h9999, 16'h0001, 16'h999A, 4'b0010, 5};
    v[3] = '{4'h1, 1'b1, 1'b1, 16'h1000, 16'h0001, 16'h0FFF, 4'b1000, 5};
    v[4] = '{4'h1, 1'b1, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 4'b0010, 5};
`endif
    v[5] = '{4'hA, 1'b0, 1'b1, 16'h1234, 16'h0001, 16'h8000, 4'b1010, 2};
    v[6] = '{4'h6, 1'b0, 1'b1, 16'h1234, 16'h0000, 16'hFFFF, 4'b0010, 5};
    v[7] = '{4'hF, 1'b0, 1'b1, 16'h1234, 16'h5678, 16'h0000, 4'b0001, 2};
    v[8] = '{4'h8, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1001, 2};
    v[9] = '{4'h2, 1'b0, 1'b1, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0010, 5};
    for (int i = 0; i < 10; i++) begin
      run_op(v[i].f, v[i].d, v[i].ci, v[i].a, v[i].b, r, fl, lat, pok);
      checks++;
      if ({r, fl} !== {v[i].r, v[i].fl}) begin
        errors++;
        $display("FAIL directed_%0d result: got r=%h cvnz=%b, want r=%h cvnz=%b",
                 i, r, fl, v[i].r, v[i].fl);
      end
      checks++;
      if (lat !== v[i].lat) begin
        errors++;
        $display("FAIL directed_%0d latency: got %0d, want %0d", i, lat, v[i].lat);
      end
      checks++;
      if (!pok) begin
        errors++;
        $display("FAIL directed_%0d done_pulse: DONE/BUSY not low or RESULT not held after pulse", i);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]   f;
    logic         d, ci;
    logic [W-1:0] a, b, r;
    logic [3:0]   fl;
    logic [W+3:0] m;
    int           lat, exp_lat;
    bit           pok;
    for (int n = 0; n < 150; n++) begin
      f  = (n % 3 == 0) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15));
      d  = 1'($urandom);
      ci = 1'($urandom);
      a  = W'($urandom);
      b  = W'($urandom);
      if (n % 2 == 0) begin
        for (int k = 0; k < W / 4; k++) begin
          a[4*k +: 4] = 4'($urandom_range(0, 9));
          b[4*k +: 4] = 4'($urandom_range(0, 9));
        end
      end
      m = model(f, d, ci, a, b);
      exp_lat = (f <= 4'h6) ? 5 : 2;
      run_op(f, d, ci, a, b, r, fl, lat, pok);
      checks++;
      if ({fl, r} !== m || lat !== exp_lat || !pok) begin
        errors++;
        $display("FAIL random_%0d f=%h d=%b ci=%b a=%h b=%h: got r=%h cvnz=%b lat=%0d pulse=%b, want r=%h cvnz=%b lat=%0d pulse=1",
                 n, f, d, ci, a, b, r, fl, lat, pok, m[W-1:0], m[W+3:W], exp_lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int           dones = 0;
    int           stray = 0;
    logic [W+3:0] m;
    m = model(4'h0, 1'b0, 1'b1, 16'h1357, 16'h2468);
    @(negedge clk);
    START = 1'b1; FUNC = 4'h0; D_FLAG = 1'b0; CARRY_IN = 1'b1; A_IN = 16'h1357; B_IN = 16'h2468;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 9) START = 1'b0;
      if (DONE) dones++;
      if (DONE && !BUSY) stray++;
    end
    checks++;
    if (dones !== 2) begin
      errors++;
      $display("FAIL back_to_back_count: got %0d DONE pulses, want 2", dones);
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL back_to_back_busy: got %0d DONE cycles with BUSY=0, want 0", stray);
    end
    checks++;
    if ({C_OUT, V_OUT, N_OUT, Z_OUT, RESULT} !== m) begin
      errors++;
      $display("FAIL back_to_back_result: got r=%h, want r=%h", RESULT, m[W-1:0]);
    end
  endtask

  task automatic test_async_reset();
    int           dones = 0;
    logic [W-1:0] r;
    logic [3:0]   fl;
    logic [W+3:0] m;
    int           lat;
    bit           pok;
    @(negedge clk);
    START = 1'b1; FUNC = 4'h0; D_FLAG = 1'b0; CARRY_IN = 1'b0; A_IN = 16'h4321; B_IN = 16'h1111;
    @(negedge clk);
    START = 1'b0;
    repeat (2) @(posedge clk);
    #2 nRESET = 1'b0;
    #1;
    checks++;
    if ({BUSY, DONE, RESULT, C_OUT, V_OUT, N_OUT, Z_OUT} !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: got busy=%b done=%b r=%h, want all 0", BUSY, DONE, RESULT);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (DONE) dones++;
    end
    nRESET = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (DONE || BUSY) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL async_reset_no_done: got %0d DONE/BUSY cycles after abort, want 0", dones);
    end
    m = model(4'h1, 1'b0, 1'b1, 16'h5000, 16'h6001);
    run_op(4'h1, 1'b0, 1'b1, 16'h5000, 16'h6001, r, fl, lat, pok);
    checks++;
    if ({fl, r} !== m || lat !== 5) begin
      errors++;
      $display("FAIL async_reset_recover: got r=%h cvnz=%b lat=%0d, want r=%h cvnz=%b lat=5",
               r, fl, lat, m[W-1:0], m[W+3:W]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
